cusw_param_router: RTL and testbench

- Parametrised successor to the control-unit software router.
- Takes NUM_POTS user potentiometer values and NUM_BANKS module-enable buttons, both from the Arduino link, and routes the pots into a per-bank register file.
- Adds enable debouncing, lowest-index bank arbitration and soft-takeover pickup, so that switching banks never causes a value jump.
- Also derives the DAC volume word with a change pulse, and drives the ready flag back to the Arduino.

---
 rtl/cusw_pkg.sv | 24 ++
 rtl/cusw_debounce.sv | 41 ++++
 rtl/cusw_param_router.sv | 189 ++++++++++++++++++
 tb/tb_cusw_param_router.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cusw_pkg.sv
// Shared FSM type, default parameters and index-width helper for the cusw router.
package cusw_pkg;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    IDLE    = 2'd1,
    SELECT  = 2'd2,
    TRACK   = 2'd3
  } cusw_state_e;

  localparam int CUSW_POT_W       = 10;
  localparam int CUSW_NUM_POTS    = 7;
  localparam int CUSW_NUM_BANKS   = 7;
  localparam int CUSW_VOL_W       = 7;
  localparam int CUSW_DEB_CYCLES  = 16;
  localparam int CUSW_HYST        = 8;
  localparam int CUSW_READY_DELAY = 256;

  // Width of an index/counter over n values, never narrower than one bit.
  function automatic int cusw_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cusw_debounce.sv
// Single-bit debouncer: output follows the input only after DEB_CYCLES
// consecutive disagreeing samples; any agreeing sample restarts the count.
module cusw_debounce
  import cusw_pkg::*;
#(
  parameter int DEB_CYCLES = CUSW_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam int            CW   = cusw_idx_w(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_r;
  logic          deb_r;

  // Count disagreeing samples and flip on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      deb_r <= 1'b0;
    end else if (raw != deb_r) begin
      if (cnt_r == LAST) begin
        cnt_r <= '0;
        deb_r <= raw;
      end else begin
        cnt_r <= cnt_r + CW'(1);
        deb_r <= deb_r;
      end
    end else begin
      cnt_r <= '0;
      deb_r <= deb_r;
    end
  end

  assign deb = deb_r;

endmodule

// File: rtl/cusw_param_router.sv
// Parametrised pot-to-bank router with debounced bank enables and volume output.
// CUSW_SOFT_TAKEOVER_EN enables soft-takeover pickup; otherwise pots write directly.
module cusw_param_router
  import cusw_pkg::*;
#(
  parameter  int POT_W       = CUSW_POT_W,
  parameter  int NUM_POTS    = CUSW_NUM_POTS,
  parameter  int NUM_BANKS   = CUSW_NUM_BANKS,
  parameter  int VOL_W       = CUSW_VOL_W,
  parameter  int DEB_CYCLES  = CUSW_DEB_CYCLES,
  parameter  int HYST        = CUSW_HYST,
  parameter  int READY_DELAY = CUSW_READY_DELAY,
  localparam int BW          = cusw_idx_w(NUM_BANKS)
) (
  input  logic                                  clk50Mhz,
  input  logic                                  RESET,
  input  logic [NUM_POTS*POT_W-1:0]             pot_in,
  input  logic [NUM_BANKS-1:0]                  bank_en,
  input  logic [POT_W-1:0]                      vol_pot,
  output logic [NUM_BANKS*NUM_POTS*POT_W-1:0]   bank_regs,
  output logic [BW-1:0]                         active_bank,
  output logic                                  bank_valid,
  output logic [NUM_POTS-1:0]                   picked,
  output logic [VOL_W-1:0]                      volume,
  output logic                                  vol_change,
  output logic                                  ready
);

  localparam int               SW         = cusw_idx_w(READY_DELAY);
  localparam logic [SW-1:0]    START_LAST = SW'(READY_DELAY - 1);
  localparam logic [POT_W:0]   HYST_D     = (POT_W + 1)'(HYST);
  localparam logic [POT_W:0]   ONE_D      = {{POT_W{1'b0}}, 1'b1};

  cusw_state_e          state_r, state_s;
  logic [SW-1:0]        start_cnt_r;
  logic [NUM_BANKS-1:0] deb_s;
  logic                 any_s;
  logic [BW-1:0]        arb_s;
  logic [BW-1:0]        active_bank_r;
  logic                 bank_valid_r;
  logic                 ready_r;
  logic [NUM_POTS-1:0]  picked_r, picked_s;
  logic [NUM_POTS-1:0]  within_s, write_s;
  logic [POT_W-1:0]     pot_s  [NUM_POTS];
  logic [POT_W-1:0]     regs_r [NUM_BANKS][NUM_POTS];
  logic [VOL_W-1:0]     volume_r, vol_next_s;
  logic                 vol_change_r;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_deb
    cusw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk (clk50Mhz),
      .rst (RESET),
      .raw (bank_en[b]),
      .deb (deb_s[b])
    );
  end

  for (genvar p = 0; p < NUM_POTS; p++) begin : g_pot
    assign pot_s[p] = pot_in[p*POT_W +: POT_W];
  end

  assign any_s = |deb_s;

  // Lowest-index debounced enable wins arbitration.
  always_comb begin
    arb_s = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      arb_s = deb_s[b] ? BW'(b) : arb_s;
    end
  end

  // Pickup window: unsigned distance between each pot and its stored value.
  always_comb begin
    logic [POT_W:0] diff_v;
    logic [POT_W:0] mag_v;
    diff_v   = '0;
    mag_v    = '0;
    within_s = '0;
    for (int p = 0; p < NUM_POTS; p++) begin
      diff_v      = {1'b0, pot_s[p]} - {1'b0, regs_r[active_bank_r][p]};
      mag_v       = diff_v[POT_W] ? (~diff_v + ONE_D) : diff_v;
      within_s[p] = (mag_v <= HYST_D);
    end
  end

  // Compare and write share an edge, so a pot that just picked up is written too.
  assign write_s = {NUM_POTS{state_r == TRACK}} & (picked_r | within_s);

  // Next-state logic for the startup/selection FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      STARTUP: begin
        if (start_cnt_r == START_LAST) state_s = IDLE;
        else                           state_s = STARTUP;
      end
      IDLE: begin
        if (any_s) state_s = SELECT;
        else       state_s = IDLE;
      end
      SELECT: begin
        if (any_s) state_s = TRACK;
        else       state_s = IDLE;
      end
      TRACK: begin
        if (!any_s)                      state_s = IDLE;
        else if (arb_s != active_bank_r) state_s = SELECT;
        else                             state_s = TRACK;
      end
      default: state_s = STARTUP;
    endcase
  end

  // Next pickup flags: cleared on selection with takeover, else all-ones while tracking.
  always_comb begin
    picked_s = picked_r;
`ifdef CUSW_SOFT_TAKEOVER_EN
    case (state_r)
      SELECT:  picked_s = {NUM_POTS{1'b0}};
      TRACK:   picked_s = picked_r | within_s;
      default: picked_s = picked_r;
    endcase
`else
    if (state_s == TRACK) picked_s = {NUM_POTS{1'b1}};
    else                  picked_s = {NUM_POTS{1'b0}};
`endif
  end

  // FSM state, startup counter and control outputs.
  always_ff @(posedge clk50Mhz) begin
    if (RESET) begin
      state_r       <= STARTUP;
      start_cnt_r   <= '0;
      active_bank_r <= '0;
      bank_valid_r  <= 1'b0;
      ready_r       <= 1'b0;
      picked_r      <= '0;
    end else begin
      state_r       <= state_s;
      start_cnt_r   <= (state_r == STARTUP) ? start_cnt_r + SW'(1) : start_cnt_r;
      active_bank_r <= (state_r == SELECT && any_s) ? arb_s : active_bank_r;
      bank_valid_r  <= (state_s == TRACK);
      ready_r       <= (state_s != STARTUP);
      picked_r      <= picked_s;
    end
  end

  // Register file: only the active bank's tracked pots are written.
  always_ff @(posedge clk50Mhz) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int p = 0; p < NUM_POTS; p++) begin
        if (RESET) begin
          regs_r[b][p] <= '0;
        end else if (write_s[p] && (active_bank_r == BW'(b))) begin
          regs_r[b][p] <= pot_s[p];
        end else begin
          regs_r[b][p] <= regs_r[b][p];
        end
      end
    end
  end

  assign vol_next_s = vol_pot[POT_W-1 -: VOL_W];

  // Volume tracks always; change pulses are suppressed until ready.
  always_ff @(posedge clk50Mhz) begin
    if (RESET) begin
      volume_r     <= '0;
      vol_change_r <= 1'b0;
    end else begin
      volume_r     <= vol_next_s;
      vol_change_r <= ready_r && (vol_next_s != volume_r);
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_flat_b
    for (genvar p = 0; p < NUM_POTS; p++) begin : g_flat_p
      assign bank_regs[(b*NUM_POTS+p)*POT_W +: POT_W] = regs_r[b][p];
    end
  end

  assign active_bank = active_bank_r;
  assign bank_valid  = bank_valid_r;
  assign picked      = picked_r;
  assign volume      = volume_r;
  assign vol_change  = vol_change_r;
  assign ready       = ready_r;

endmodule

// File: tb/tb_cusw_param_router.sv
// Directed scoreboard bench for cusw_param_router at default parameters.
`timescale 1ns/1ps
module tb_cusw_param_router;

  localparam int POT_W     = 10;
  localparam int NUM_POTS  = 7;
  localparam int NUM_BANKS = 7;
  localparam int VOL_W     = 7;
  localparam int BW        = 3;
`ifdef CUSW_SOFT_TAKEOVER_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic                                clk50Mhz = 1'b0;
  logic                                RESET    = 1'b1;
  logic [NUM_POTS*POT_W-1:0]           pot_in   = '0;
  logic [NUM_BANKS-1:0]                bank_en  = '0;
  logic [POT_W-1:0]                    vol_pot  = '0;
  logic [NUM_BANKS*NUM_POTS*POT_W-1:0] bank_regs;
  logic [BW-1:0]                       active_bank;
  logic                                bank_valid;
  logic [NUM_POTS-1:0]                 picked;
  logic [VOL_W-1:0]                    volume;
  logic                                vol_change;
  logic                                ready;

  always #10 clk50Mhz = ~clk50Mhz;

  cusw_param_router #(
    .POT_W(POT_W), .NUM_POTS(NUM_POTS), .NUM_BANKS(NUM_BANKS), .VOL_W(VOL_W),
    .DEB_CYCLES(16), .HYST(8), .READY_DELAY(256)
  ) dut (
    .clk50Mhz(clk50Mhz), .RESET(RESET), .pot_in(pot_in), .bank_en(bank_en),
    .vol_pot(vol_pot), .bank_regs(bank_regs), .active_bank(active_bank),
    .bank_valid(bank_valid), .picked(picked), .volume(volume),
    .vol_change(vol_change), .ready(ready)
  );

  logic [63:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          waited;
  int          pulses;

  task automatic step(input int n);
    repeat (n) @(posedge clk50Mhz);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [63:0] obs);
    logic [63:0] e;
    string       t;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_underflow: observed %0h, nothing expected", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  function automatic logic [POT_W-1:0] reg_of(input int b, input int p);
    return bank_regs[(b*NUM_POTS+p)*POT_W +: POT_W];
  endfunction

  task automatic set_pot(input int p, input int v);
    pot_in[p*POT_W +: POT_W] = POT_W'(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(2);
    expect_val("rst_ready", 0);   check(ready);
    expect_val("rst_valid", 0);   check(bank_valid);
    expect_val("rst_active", 0);  check(active_bank);
    expect_val("rst_picked", 0);  check(picked);
    expect_val("rst_volume", 0);  check(volume);
    expect_val("rst_regs", 1);    check(bank_regs == '0);

    // Startup: ready low for 256 cycles, bank 0 selected shortly after
    bank_en = 7'b0000001;
    RESET   = 1'b0;
    for (int i = 0; i < 255; i++) begin
      step(1);
      expect_val("startup_ready_low", 0); check(ready);
    end
    expect_val("startup_valid_low", 0); check(bank_valid);
    step(1);
    expect_val("startup_ready_high", 1); check(ready);
    waited = 0;
    while (!bank_valid && waited < 19) begin
      step(1);
      waited++;
    end
    expect_val("startup_valid_by_275", 1); check(bank_valid);
    expect_val("startup_bank0", 0);        check(active_bank);

    // Volume sweep after ready
    pulses = 0;
    for (int v = 1; v < 1024; v++) begin
      vol_pot = POT_W'(v);
      expect_val("vol_value", v >> 3);
      expect_val("vol_change", ((v >> 3) != ((v - 1) >> 3)) ? 1 : 0);
      step(1);
      check(volume);
      check(vol_change);
      if (vol_change) pulses++;
    end
    expect_val("vol_pulse_count", 127); check(pulses);
    step(1);
    expect_val("vol_change_idle", 0); check(vol_change);

    // Bank 0 tracking: one-cycle write latency
    for (int p = 0; p < NUM_POTS; p++) set_pot(p, 100*p + 37);
    step(1);
    for (int p = 0; p < NUM_POTS; p++) begin
      expect_val("track_b0_pat1", 100*p + 37); check(reg_of(0, p));
    end
    expect_val("track_b0_picked", 7'h7f); check(picked);
    for (int p = 0; p < NUM_POTS; p++) set_pot(p, 1023 - 50*p);
    step(1);
    for (int p = 0; p < NUM_POTS; p++) begin
      expect_val("track_b0_pat2", 1023 - 50*p); check(reg_of(0, p));
    end

    // Release: IDLE holds registers and active_bank
    bank_en = 7'b0000000;
    step(20);
    expect_val("idle_valid", 0);  check(bank_valid);
    expect_val("idle_active", 0); check(active_bank);
    for (int p = 0; p < NUM_POTS; p++) set_pot(p, 200 + 90*p);
    step(2);
    for (int p = 0; p < NUM_POTS; p++) begin
      expect_val("idle_hold_b0", 1023 - 50*p); check(reg_of(0, p));
    end

    // Debounce: 10-cycle glitch ignored, 16-cycle hold accepted
    bank_en = 7'b0000100; step(10);
    bank_en = 7'b0000000; step(20);
    expect_val("glitch_valid", 0);  check(bank_valid);
    expect_val("glitch_active", 0); check(active_bank);
    bank_en = 7'b0000100;
    step(17);
    expect_val("deb_select_active", 0); check(active_bank);
    expect_val("deb_select_valid", 0);  check(bank_valid);
    step(1);
    expect_val("deb_bank2", 2);       check(active_bank);
    expect_val("deb_bank2_valid", 1); check(bank_valid);
    step(1);
    expect_val("b2_first_write", SOFT ? 0 : 200); check(reg_of(2, 0));
    expect_val("b2_picked", SOFT ? 7'h00 : 7'h7f); check(picked);

    // Store 500 in bank 1 pot 0
    set_pot(0, 0);
    bank_en = 7'b0000110;
    step(19);
    expect_val("b1_active", 1); check(active_bank);
    set_pot(0, 500);
    step(1);
    expect_val("b1_store500", 500); check(reg_of(1, 0));

    // Park on bank 2, move pot 0 away, return to bank 1
    bank_en = 7'b0000100;
    step(19);
    expect_val("park_b2", 2); check(active_bank);
    set_pot(0, 100);
    step(1);
    bank_en = 7'b0000110;
    step(18);
    expect_val("return_b1", 1);          check(active_bank);
    expect_val("return_b1_reg", 500);    check(reg_of(1, 0));
    expect_val("return_b1_picked0", SOFT ? 0 : 1); check(picked[0]);

    // Sweep towards the stored value, then back down
    for (int v = 100; v <= 492; v += 4) begin
      set_pot(0, v);
      step(1);
      expect_val("sweep_up_reg", (SOFT && v < 492) ? 500 : v); check(reg_of(1, 0));
      expect_val("sweep_up_picked0", (SOFT && v < 492) ? 0 : 1); check(picked[0]);
    end
    for (int v = 488; v >= 300; v -= 4) begin
      set_pot(0, v);
      step(1);
      expect_val("sweep_down_reg", v); check(reg_of(1, 0));
    end
    expect_val("sweep_down_picked0", 1); check(picked[0]);

    // Arbitration: lowest index wins, dropping it reselects
    bank_en = 7'b0011000;
    step(18);
    expect_val("arb_bank3", 3);       check(active_bank);
    expect_val("arb_bank3_valid", 1); check(bank_valid);
    bank_en = 7'b0010000;
    step(17);
    expect_val("arb_select_valid", 0); check(bank_valid);
    expect_val("arb_select_active", 3); check(active_bank);
    step(1);
    expect_val("arb_bank4", 4);        check(active_bank);
    expect_val("arb_bank4_picked", SOFT ? 7'h00 : 7'h7f); check(picked);

    // Reset during bank 0 tracking
    bank_en = 7'b0000001;
    step(19);
    expect_val("pre_rst_active", 0); check(active_bank);
    expect_val("pre_rst_valid", 1);  check(bank_valid);
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    expect_val("mid_rst_regs", 1);   check(bank_regs == '0);
    expect_val("mid_rst_ready", 0);  check(ready);
    expect_val("mid_rst_valid", 0);  check(bank_valid);
    expect_val("mid_rst_picked", 0); check(picked);
    expect_val("mid_rst_volume", 0); check(volume);
    step(1);
    expect_val("startup_vol_tracks", 127); check(volume);
    expect_val("startup_no_change", 0);    check(vol_change);
    step(10);
    expect_val("restart_ready_low", 0); check(ready);

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
